// File: rtl/time_set_ctrl_if.sv
// time_set_ctrl_if
//   Groups the key inputs, the live-time preload digits and the set-mode
//   outputs of time_set_ctrl into one bundle.
//   Handshake: none. The keys are raw asynchronous levels. The cur_* digits
//   are sampled only on the cycle a mode press leaves RUN. Every output is a
//   plain register that is valid on every cycle.
//   Modports:
//     master - environment side: drives keys and cur_*, observes outputs.
//     slave  - time_set_ctrl side: receives keys and cur_*, drives outputs.
//   dbg_state mirrors the FSM state register: 0 RUN, 1 SET_HOUR, 2 SET_MIN.
interface time_set_ctrl_if;
  logic       key_mode;
  logic       key_inc;
  logic [3:0] cur_hour1;
  logic [3:0] cur_hour0;
  logic [3:0] cur_min1;
  logic [3:0] cur_min0;
  logic       timeSetMode;
  logic [3:0] hour_set1;
  logic [3:0] hour_set0;
  logic [3:0] min_set1;
  logic [3:0] min_set0;
  logic [1:0] set_field;
  logic [1:0] dbg_state;

  modport master (
    output key_mode, key_inc, cur_hour1, cur_hour0, cur_min1, cur_min0,
    input  timeSetMode, hour_set1, hour_set0, min_set1, min_set0,
    input  set_field, dbg_state
  );

  modport slave (
    input  key_mode, key_inc, cur_hour1, cur_hour0, cur_min1, cur_min0,
    output timeSetMode, hour_set1, hour_set0, min_set1, min_set0,
    output set_field, dbg_state
  );
endinterface

// File: rtl/time_set_ctrl.sv
// time_set_ctrl
//   Set-mode controller for the hour and minute counters. It debounces the
//   raw mode and increment buttons and turns each debounced press into a
//   one-cycle pulse. A three-state FSM (RUN -> SET_HOUR -> SET_MIN -> RUN)
//   then produces the BCD load digits and the timeSetMode load enable.
//   Ports:
//     clk   - system clock; all state updates on the rising edge
//     rst_n - asynchronous active-low reset
//     bus   - time_set_ctrl_if.slave: keys, cur_* preload digits, outputs
//   Parameters:
//     DEBOUNCE_CYCLES - cycles a synchronised key must differ from its
//                       debounced level before the level flips (>= 2)
//     DB_CNT_W        - debounce counter width, 2**DB_CNT_W > DEBOUNCE_CYCLES
//   Key timing: when a raw key is stable high from edge 0, its press pulse
//   is sampled by the FSM at edge DEBOUNCE_CYCLES+3.
module time_set_ctrl #(
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int DB_CNT_W        = 8
) (
  input logic           clk,
  input logic           rst_n,
  time_set_ctrl_if.slave bus
);

  // The level flips on the edge where the counter would reach
  // DEBOUNCE_CYCLES, so the counter compares against one less than that.
  localparam logic [DB_CNT_W-1:0] DB_LAST = DB_CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_SET_HOUR = 2'b01,
    ST_SET_MIN  = 2'b10
  } state_t;

  // Key index 0 is mode and index 1 is increment.
  logic [1:0]          raw_keys;
  logic [1:0]          sync1_q, sync2_q;
  logic [1:0]          db_q, db_d;
  logic [1:0]          db_dly_q;
  logic [1:0]          press_q;
  logic [DB_CNT_W-1:0] cnt_q [2];
  logic [DB_CNT_W-1:0] cnt_d [2];

  assign raw_keys = {bus.key_inc, bus.key_mode};

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      db_d[i]  = db_q[i];
      cnt_d[i] = '0;
      if (sync2_q[i] != db_q[i]) begin
        if (cnt_q[i] == DB_LAST) begin
          db_d[i] = ~db_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      db_q     <= '0;
      db_dly_q <= '0;
      press_q  <= '0;
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
    end else begin
      sync1_q  <= raw_keys;
      sync2_q  <= sync1_q;
      db_q     <= db_d;
      db_dly_q <= db_q;
      // Rising edge of the debounced level only. A held key never pulses again.
      press_q  <= db_q & ~db_dly_q;
      cnt_q[0] <= cnt_d[0];
      cnt_q[1] <= cnt_d[1];
    end
  end

  logic mode_p, inc_p;
  assign mode_p = press_q[0];
  assign inc_p  = press_q[1];

  // An invalid pair is one with any digit above 9, an hour above 23 or a
  // minute above 59. Such a pair preloads as 0,0.
  logic hour_ok, min_ok;
  assign hour_ok = (bus.cur_hour0 <= 4'd9) &&
                   ((bus.cur_hour1 < 4'd2) ||
                    ((bus.cur_hour1 == 4'd2) && (bus.cur_hour0 <= 4'd3)));
  assign min_ok  = (bus.cur_min1 <= 4'd5) && (bus.cur_min0 <= 4'd9);

  state_t     state_q, state_d;
  logic       tsm_q, tsm_d;
  logic [1:0] field_q, field_d;
  logic [3:0] h1_q, h1_d, h0_q, h0_d, m1_q, m1_d, m0_q, m0_d;

  always_comb begin
    state_d = state_q;
    h1_d    = h1_q;
    h0_d    = h0_q;
    m1_d    = m1_q;
    m0_d    = m0_q;
    unique case (state_q)
      ST_RUN: begin
        if (mode_p) begin
          state_d = ST_SET_HOUR;
          h1_d    = hour_ok ? bus.cur_hour1 : 4'd0;
          h0_d    = hour_ok ? bus.cur_hour0 : 4'd0;
          m1_d    = min_ok  ? bus.cur_min1  : 4'd0;
          m0_d    = min_ok  ? bus.cur_min0  : 4'd0;
        end
      end
      ST_SET_HOUR: begin
        // Mode takes priority, so an inc pulse in the same cycle is dropped.
        if (mode_p) begin
          state_d = ST_SET_MIN;
        end else if (inc_p) begin
          if ((h1_q == 4'd2) && (h0_q == 4'd3)) begin
            h1_d = 4'd0;
            h0_d = 4'd0;
          end else if (h0_q == 4'd9) begin
            h1_d = h1_q + 4'd1;
            h0_d = 4'd0;
          end else begin
            h0_d = h0_q + 4'd1;
          end
        end
      end
      ST_SET_MIN: begin
        if (mode_p) begin
          state_d = ST_RUN;
        end else if (inc_p) begin
          // The 59 -> 00 wrap stays inside the minute pair. It never
          // carries into the hours.
          if (m0_q == 4'd9) begin
            m0_d = 4'd0;
            m1_d = (m1_q == 4'd5) ? 4'd0 : m1_q + 4'd1;
          end else begin
            m0_d = m0_q + 4'd1;
          end
        end
      end
      default: state_d = ST_RUN;
    endcase
    // timeSetMode and set_field are registered copies of the next state. They
    // change on the same edge as the FSM and decode no logic after the flops.
    tsm_d   = (state_d != ST_RUN);
    field_d = state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      tsm_q   <= 1'b0;
      field_q <= 2'b00;
      h1_q    <= '0;
      h0_q    <= '0;
      m1_q    <= '0;
      m0_q    <= '0;
    end else begin
      state_q <= state_d;
      tsm_q   <= tsm_d;
      field_q <= field_d;
      h1_q    <= h1_d;
      h0_q    <= h0_d;
      m1_q    <= m1_d;
      m0_q    <= m0_d;
    end
  end

  assign bus.timeSetMode = tsm_q;
  assign bus.set_field   = field_q;
  assign bus.hour_set1   = h1_q;
  assign bus.hour_set0   = h0_q;
  assign bus.min_set1    = m1_q;
  assign bus.min_set0    = m0_q;
  assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
module tb_time_set_ctrl;

  localparam int D = 20;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  time_set_ctrl_if bus ();

  time_set_ctrl #(.DEBOUNCE_CYCLES(D), .DB_CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: expected values queue, compared in order
  logic [20:0] exp_q[$];

  // Packed expected/actual vector: {tsm, field, dbg_state, h1, h0, m1, m0}
  task automatic check_all(input string nm, input logic tsm, input logic [1:0] fld,
                           input logic [3:0] h1, input logic [3:0] h0,
                           input logic [3:0] m1, input logic [3:0] m0);
    logic [20:0] act;
    logic [20:0] expv;
    exp_q.push_back({tsm, fld, fld, h1, h0, m1, m0});
    expv = exp_q.pop_front();
    act  = {bus.timeSetMode, bus.set_field, bus.dbg_state,
            bus.hour_set1, bus.hour_set0, bus.min_set1, bus.min_set0};
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got tsm/field/state/digits=%h required=%h", nm, act, expv);
    end
  endtask

  // Driver tasks
  task automatic set_cur(input logic [3:0] h1, input logic [3:0] h0,
                         input logic [3:0] m1, input logic [3:0] m0);
    @(negedge clk);
    bus.cur_hour1 = h1;
    bus.cur_hour0 = h0;
    bus.cur_min1  = m1;
    bus.cur_min0  = m0;
  endtask

  // Press and release cleanly. The task ends on a negedge so the caller can
  // sample right after it.
  task automatic press(input logic m, input logic i);
    @(negedge clk);
    bus.key_mode = m;
    bus.key_inc  = i;
    repeat (D + 6) @(posedge clk);
    @(negedge clk);
    bus.key_mode = 1'b0;
    bus.key_inc  = 1'b0;
    repeat (D + 6) @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic [3:0] h1, h0, m1, m0;   // cur_* preload
    int         nh, nm;           // inc presses in SET_HOUR / SET_MIN
    logic [3:0] ph1, ph0, pm1, pm0; // digits after preload
    logic [3:0] ah1, ah0, am1, am0; // digits after the inc presses
  } vec_t;

  vec_t vec [6];

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    bus.key_mode  = 1'b0;
    bus.key_inc   = 1'b0;
    bus.cur_hour1 = '0;
    bus.cur_hour0 = '0;
    bus.cur_min1  = '0;
    bus.cur_min0  = '0;

    vec[0] = '{4'd2, 4'd1, 4'd5, 4'd8, 3, 2,  4'd2, 4'd1, 4'd5, 4'd8,  4'd0, 4'd0, 4'd0, 4'd0};
    vec[1] = '{4'd2, 4'd7, 4'd1, 4'd3, 0, 0,  4'd0, 4'd0, 4'd1, 4'd3,  4'd0, 4'd0, 4'd1, 4'd3};
    vec[2] = '{4'd0, 4'd9, 4'd4, 4'd9, 1, 1,  4'd0, 4'd9, 4'd4, 4'd9,  4'd1, 4'd0, 4'd5, 4'd0};
    vec[3] = '{4'd1, 4'hA, 4'd6, 4'd0, 2, 0,  4'd0, 4'd0, 4'd0, 4'd0,  4'd0, 4'd2, 4'd0, 4'd0};
    vec[4] = '{4'd1, 4'd9, 4'd5, 4'd9, 1, 1,  4'd1, 4'd9, 4'd5, 4'd9,  4'd2, 4'd0, 4'd0, 4'd0};
    vec[5] = '{4'd2, 4'd3, 4'd0, 4'd0, 1, 11, 4'd2, 4'd3, 4'd0, 4'd0,  4'd0, 4'd0, 4'd1, 4'd1};

    // Reset held while the keys toggle
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      bus.key_mode = k[0];
      bus.key_inc  = k[1];
    end
    check_all("reset_hold", 1'b0, 2'b00, 4'd0, 4'd0, 4'd0, 4'd0);
    @(negedge clk);
    bus.key_mode = 1'b0;
    bus.key_inc  = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(posedge clk);
    @(negedge clk);
    check_all("reset_release_idle", 1'b0, 2'b00, 4'd0, 4'd0, 4'd0, 4'd0);

    // Table-driven preload / increment / wrap sequences
    for (int v = 0; v < 6; v++) begin
      set_cur(vec[v].h1, vec[v].h0, vec[v].m1, vec[v].m0);
      press(1'b1, 1'b0);
      check_all($sformatf("v%0d_preload", v), 1'b1, 2'b01,
                vec[v].ph1, vec[v].ph0, vec[v].pm1, vec[v].pm0);
      for (int n = 0; n < vec[v].nh; n++) press(1'b0, 1'b1);
      check_all($sformatf("v%0d_hour_inc", v), 1'b1, 2'b01,
                vec[v].ah1, vec[v].ah0, vec[v].pm1, vec[v].pm0);
      press(1'b1, 1'b0);
      check_all($sformatf("v%0d_to_set_min", v), 1'b1, 2'b10,
                vec[v].ah1, vec[v].ah0, vec[v].pm1, vec[v].pm0);
      for (int n = 0; n < vec[v].nm; n++) press(1'b0, 1'b1);
      check_all($sformatf("v%0d_min_inc", v), 1'b1, 2'b10,
                vec[v].ah1, vec[v].ah0, vec[v].am1, vec[v].am0);
      press(1'b1, 1'b0);
      check_all($sformatf("v%0d_back_run", v), 1'b0, 2'b00,
                vec[v].ah1, vec[v].ah0, vec[v].am1, vec[v].am0);
      // In RUN, an inc is ignored and new cur_* values are not loaded
      set_cur(4'd1, 4'd1, 4'd1, 4'd1);
      press(1'b0, 1'b1);
      check_all($sformatf("v%0d_run_inc_ignored", v), 1'b0, 2'b00,
                vec[v].ah1, vec[v].ah0, vec[v].am1, vec[v].am0);
    end

    // Glitch rejection and debounce latency in SET_HOUR
    set_cur(4'd1, 4'd2, 4'd3, 4'd4);
    press(1'b1, 1'b0);
    check_all("db_enter", 1'b1, 2'b01, 4'd1, 4'd2, 4'd3, 4'd4);
    @(negedge clk);
    bus.key_inc = 1'b1;
    repeat (D - 2) @(posedge clk);
    @(negedge clk);
    bus.key_inc = 1'b0;
    repeat (2 * D) @(posedge clk);
    @(negedge clk);
    check_all("glitch_rejected", 1'b1, 2'b01, 4'd1, 4'd2, 4'd3, 4'd4);
    @(negedge clk);
    bus.key_inc = 1'b1;
    for (int k = 0; k <= D + 3; k++) begin
      @(posedge clk);
      #1;
      if (k == D + 2) check_all("db_before_edge", 1'b1, 2'b01, 4'd1, 4'd2, 4'd3, 4'd4);
      if (k == D + 3) check_all("db_at_edge", 1'b1, 2'b01, 4'd1, 4'd3, 4'd3, 4'd4);
    end
    repeat (40 - (D + 4)) @(posedge clk);
    @(negedge clk);
    bus.key_inc = 1'b0;
    repeat (D + 10) @(posedge clk);
    @(negedge clk);
    check_all("held_single_inc", 1'b1, 2'b01, 4'd1, 4'd3, 4'd3, 4'd4);
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    check_all("db_exit", 1'b0, 2'b00, 4'd1, 4'd3, 4'd3, 4'd4);

    // Mode and inc in the same cycle: mode wins and the inc is dropped
    set_cur(4'd0, 4'd5, 4'd3, 4'd3);
    press(1'b1, 1'b0);
    check_all("simul_enter", 1'b1, 2'b01, 4'd0, 4'd5, 4'd3, 4'd3);
    press(1'b1, 1'b1);
    check_all("simul_mode_wins", 1'b1, 2'b10, 4'd0, 4'd5, 4'd3, 4'd3);

    // Asynchronous reset mid-cycle while in SET_MIN
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_all("async_reset_immediate", 1'b0, 2'b00, 4'd0, 4'd0, 4'd0, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_all("after_async_reset", 1'b0, 2'b00, 4'd0, 4'd0, 4'd0, 4'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Bounded run time
  initial begin
    #900000;
    $display("FAIL timeout: simulation time limit reached");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/time_set_ctrl.md
Name: time_set_ctrl

Overview:
Upstream control stage for the hour and minute counters. It debounces two raw push-buttons (mode, increment) and runs a small set-mode FSM. The FSM produces timeSetMode plus the BCD set digits that the hour counter loads (hour_set1/hour_set0) and the minute counter loads (min_set1/min_set0). It runs on the system clock, not the 1 Hz tick.

Parameters:
DEBOUNCE_CYCLES, 20, consecutive cycles a synchronised key must differ from its debounced level before that level flips (minimum 2)
DB_CNT_W, 8, width of each debounce counter; must satisfy 2^DB_CNT_W > DEBOUNCE_CYCLES

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
key_mode  input  1  raw mode button, active-high, asynchronous to clk
key_inc  input  1  raw increment button, active-high, asynchronous to clk
cur_hour1  input  4  live hour tens digit (BCD), preload source
cur_hour0  input  4  live hour units digit (BCD)
cur_min1  input  4  live minute tens digit (BCD)
cur_min0  input  4  live minute units digit (BCD)
timeSetMode  output  1  high while in either set state; drives counter load
hour_set1  output  4  hour tens digit to load, 0-2
hour_set0  output  4  hour units digit to load, 0-9
min_set1  output  4  minute tens digit to load, 0-5
min_set0  output  4  minute units digit to load, 0-9
set_field  output  2  active field: 00 none, 01 hour, 10 minute (for display blink)

Behaviour:
- Reset (async, rst_n=0):
  - FSM to RUN; all outputs 0.
  - Synchroniser flops, debounced levels and debounce counters cleared.
  - Reset mid-set drops timeSetMode immediately.
- Per-key front end:
  - 2-flop synchroniser.
  - Counter increments each cycle the synced value differs from the debounced level and clears when they match.
  - When the counter reaches DEBOUNCE_CYCLES the debounced level flips and the counter clears.
- Press pulse:
  - One-cycle pulse on the debounced rising edge only; no pulse on release.
  - No auto-repeat while held.
  - A raw key stable high from edge 0 gives its press pulse first high at edge DEBOUNCE_CYCLES+3.
  - Glitches shorter than DEBOUNCE_CYCLES cycles produce no pulse.
- FSM states: RUN(set_field=00), SET_HOUR(01), SET_MIN(10).
- RUN:
  - On mode press: go to SET_HOUR.
  - Load hour_set*/min_set* from cur_* in the same edge.
  - A pair with an invalid preload (hour >23, minute >59, or any digit >9) loads 0,0 for that pair.
  - inc presses ignored; set digits hold their last values.
- SET_HOUR:
  - On inc press: hour pair increments as BCD.
  - Units 9 wraps to 0 with tens +1.
  - 23 wraps to 00.
  - On mode press: go to SET_MIN.
- SET_MIN:
  - On inc press: minute pair increments as BCD; 59 wraps to 00.
  - On mode press: go to RUN.
- timeSetMode is registered and is 1 exactly in SET_HOUR and SET_MIN.
  - It rises on the same edge the FSM leaves RUN and falls on the edge it returns to RUN.
- Simultaneous mode and inc press in one cycle: mode wins and that inc is discarded.
- An increment never affects the non-selected pair.
- No carry from minutes into hours.
- Set outputs are plain registers with no combinational path from key inputs.

Test Plan:
1. Reset, then hold rst_n=0 with keys toggling -> all outputs 0, state RUN. Release -> outputs stay 0 with no key activity.
2. key_inc glitch high for DEBOUNCE_CYCLES-2 cycles in SET_HOUR -> hour_set unchanged. Then hold high 40 cycles -> exactly one increment, first visible at edge DEBOUNCE_CYCLES+3.
3. Wrap with cur_hour=2,1 and cur_min=5,8:
   - mode press -> timeSetMode=1, set_field=01, hour_set=2,1, min_set=5,8.
   - 3 inc presses -> hour 2,2 / 2,3 / 0,0.
   - mode press -> set_field=10; 2 inc presses -> min 5,9 / 0,0.
   - mode press -> timeSetMode=0, set_field=00, digits hold 0,0 / 0,0.
4. Invalid preload cur_hour=2,7, cur_min=1,3 -> mode press loads hour_set=0,0, min_set=1,3. From hour 0,9, one inc -> 1,0.
5. In SET_HOUR, mode and inc pulses on the same cycle -> state SET_MIN, hour_set unchanged, min_set unchanged.
6. In SET_MIN, assert rst_n=0 asynchronously mid-cycle -> timeSetMode low before the next clk edge, all digits 0, state RUN after release.
